// File: rtl/mc_maindec.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback
// with a mem_req/mem_ready handshake. Define MC_MAINDEC_PERF_EN for performance counters.
module mc_maindec #(
  parameter int unsigned OP_W            = 6,
  parameter int unsigned CNT_W           = 32,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OP_W-1:0]  op,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             iord,
  output logic             memwrite,
  output logic             irwrite,
  output logic             pcwrite,
  output logic             branch,
  output logic             branch_ne,
  output logic             regdst,
  output logic             memtoreg,
  output logic             regwrite,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       pcsrc,
  output logic [1:0]       aluop,
  output logic             instr_done,
  output logic             illegal_op,
  output logic [3:0]       state
`ifdef MC_MAINDEC_PERF_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  // Upper opcode bits must be zero for a match.
  localparam logic [OP_W-1:0] OpRtype = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OpJ     = OP_W'(6'b000010);
  localparam logic [OP_W-1:0] OpBeq   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OpBne   = OP_W'(6'b000101);
  localparam logic [OP_W-1:0] OpAddi  = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OpLw    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OpSw    = OP_W'(6'b101011);

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAdr  = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StExecute = 4'd6,
    StAluWb   = 4'd7,
    StBranch  = 4'd8,
    StAddiEx  = 4'd9,
    StAddiWb  = 4'd10,
    StJump    = 4'd11,
    StIllegal = 4'd12
  } state_e;

  state_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch:   if (mem_ready) state_d = StDecode;
      StDecode: begin
        case (op)
          OpLw, OpSw:   state_d = StMemAdr;
          OpRtype:      state_d = StExecute;
          OpBeq, OpBne: state_d = StBranch;
          OpAddi:       state_d = StAddiEx;
          OpJ:          state_d = StJump;
          default:      state_d = StIllegal;
        endcase
      end
      StMemAdr:  state_d = (op == OpLw) ? StMemRd : StMemWr;
      StMemRd:   if (mem_ready) state_d = StMemWb;
      StMemWr:   if (mem_ready) state_d = StFetch;
      StExecute: state_d = StAluWb;
      StAddiEx:  state_d = StAddiWb;
      StMemWb, StAluWb, StBranch, StAddiWb, StJump: state_d = StFetch;
      StIllegal: if (!HALT_ON_ILLEGAL) state_d = StFetch;
      default:   state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StFetch;
    else        state_q <= state_d;
  end

  assign state = state_q;

  // Outputs are gated by rst_n so an asserted reset kills any in-flight write at once.
  always_comb begin
    mem_req    = 1'b0;
    iord       = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    branch_ne  = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    aluop      = 2'b00;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    if (rst_n) begin
      case (state_q)
        StFetch: begin
          mem_req = 1'b1;
          alusrcb = 2'b01;
          irwrite = mem_ready;
          pcwrite = mem_ready;
        end
        StDecode: alusrcb = 2'b11;
        StMemAdr: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
        end
        StMemRd: begin
          mem_req = 1'b1;
          iord    = 1'b1;
        end
        StMemWb: begin
          memtoreg   = 1'b1;
          regwrite   = 1'b1;
          instr_done = 1'b1;
        end
        StMemWr: begin
          mem_req    = 1'b1;
          iord       = 1'b1;
          memwrite   = 1'b1;
          instr_done = mem_ready;
        end
        StExecute: begin
          alusrca = 1'b1;
          aluop   = 2'b10;
        end
        StAluWb: begin
          regdst     = 1'b1;
          regwrite   = 1'b1;
          instr_done = 1'b1;
        end
        StBranch: begin
          alusrca    = 1'b1;
          aluop      = 2'b01;
          pcsrc      = 2'b01;
          branch     = 1'b1;
          branch_ne  = (op == OpBne);
          instr_done = 1'b1;
        end
        StAddiEx: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
        end
        StAddiWb: begin
          regwrite   = 1'b1;
          instr_done = 1'b1;
        end
        StJump: begin
          pcsrc      = 2'b10;
          pcwrite    = 1'b1;
          instr_done = 1'b1;
        end
        StIllegal: illegal_op = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef MC_MAINDEC_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (instr_done)            instr_cnt <= instr_cnt + CNT_W'(1);
      if (mem_req && !mem_ready) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
`endif

endmodule
